// File: rtl/io_bridge_pkg.sv
// Shared constants and read-select decode for the CPU-to-board IO bridge.
package io_bridge_pkg;

   localparam int         DATA_W     = 24;
   localparam logic [7:0] ADDR_LED   = 8'h60;
   localparam logic [7:0] ADDR_SW    = 8'h70;
   localparam logic [7:0] ADDR_SWCHG = 8'h74;

   typedef enum logic [1:0] {
      SEL_LED,
      SEL_SW,
      SEL_CHG,
      SEL_NONE
   } rsel_e;

   function automatic rsel_e decode(input logic [7:0] addr);
      case (addr)
         ADDR_LED:   return SEL_LED;
         ADDR_SW:    return SEL_SW;
         ADDR_SWCHG: return SEL_CHG;
         default:    return SEL_NONE;
      endcase
   endfunction

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchronizer followed by a whole-vector debouncer; changed_pulse is
// high in the cycle the debounced value is loaded.
module sw_debounce #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int W               = 24
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] raw,
   output logic [W-1:0] stable,
   output logic         changed_pulse
);

   localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic [W-1:0]  sync1_q, sync2_q, prev_q, stable_q, stable_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          differ, moved, load;

   // A sample that moved since the last cycle counts as the first stable one.
   always_comb begin
      differ   = (sync2_q != stable_q);
      moved    = (sync2_q != prev_q);
      load     = differ && !moved && (cnt_q == CNT_MAX);
      cnt_d    = cnt_q;
      stable_d = stable_q;
      if (!differ) begin
         cnt_d = '0;
      end else if (moved) begin
         cnt_d = CW'(1);
      end else if (load) begin
         stable_d = sync2_q;
         cnt_d    = '0;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         prev_q   <= '0;
         stable_q <= '0;
         cnt_q    <= '0;
      end else begin
         sync1_q  <= raw;
         sync2_q  <= sync1_q;
         prev_q   <= sync2_q;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
      end
   end

   assign stable        = stable_q;
   assign changed_pulse = load;

endmodule

// File: rtl/io_bridge.sv
// CPU IO bridge: LED register, debounced switches and a read-to-clear change
// flag, each request completing with a one-cycle io_ready pulse.
module io_bridge
   import io_bridge_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              io_sel,
   input  logic              io_we,
   input  logic [7:0]        io_addr,
   input  logic [DATA_W-1:0] io_wdata,
   output logic [DATA_W-1:0] io_rdata,
   output logic              io_ready,
   input  logic [DATA_W-1:0] sw,
   output logic [DATA_W-1:0] led
);

   logic [DATA_W-1:0] led_q, led_d, rdata_q, rdata_d, sw_stable;
   logic              ready_q, flag_q, flag_d, sw_chg, rd, wr;
   rsel_e             rsel;

   sw_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .W              (DATA_W)
   ) u_sw_debounce (
      .clk          (clk),
      .rst          (rst),
      .raw          (sw),
      .stable       (sw_stable),
      .changed_pulse(sw_chg)
   );

   always_comb begin
      rd      = io_sel && !io_we;
      wr      = io_sel && io_we;
      rsel    = decode(io_addr);
      led_d   = (wr && rsel == SEL_LED) ? io_wdata : led_q;
      rdata_d = rdata_q;
      if (rd) begin
         case (rsel)
            SEL_LED: rdata_d = led_q;
            SEL_SW:  rdata_d = sw_stable;
            SEL_CHG: rdata_d = {{(DATA_W-1){1'b0}}, flag_q};
            default: rdata_d = '0;
         endcase
      end
      // A new debounce event outranks a clearing read in the same cycle.
      flag_d = (flag_q && !(rd && rsel == SEL_CHG)) || sw_chg;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         led_q   <= '0;
         rdata_q <= '0;
         ready_q <= 1'b0;
         flag_q  <= 1'b0;
      end else begin
         led_q   <= led_d;
         rdata_q <= rdata_d;
         ready_q <= io_sel;
         flag_q  <= flag_d;
      end
   end

   assign led      = led_q;
   assign io_rdata = rdata_q;
   assign io_ready = ready_q;

endmodule

// File: tb/tb_io_bridge.sv
// Scoreboarded bench for io_bridge: a behavioural model queues each expected
// completion and a negedge monitor compares io_ready, io_rdata and led.
module tb_io_bridge;
   import io_bridge_pkg::*;

   localparam int D = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        io_sel, io_we;
   logic [7:0]  io_addr;
   logic [23:0] io_wdata, io_rdata, sw, led;
   logic        io_ready;

   always #5 clk = ~clk;

   io_bridge #(.DEBOUNCE_CYCLES(D)) dut (
      .clk     (clk),
      .rst     (rst),
      .io_sel  (io_sel),
      .io_we   (io_we),
      .io_addr (io_addr),
      .io_wdata(io_wdata),
      .io_rdata(io_rdata),
      .io_ready(io_ready),
      .sw      (sw),
      .led     (led)
   );

   typedef struct {
      logic [23:0] rdata;
      logic [23:0] led;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   passed = 0;

   task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
   endtask

   // Reference model: the switch vector seen by the debouncer is sw delayed
   // two clocks; it is adopted once the last D samples agree and differ from
   // the current debounced value.
   logic [23:0] m_led, m_rdata, m_stable;
   logic        m_flag;
   logic [23:0] m_pipe[2];
   logic [23:0] m_win[$];

   always @(posedge clk) begin : model
      logic [23:0] smp;
      bit          upd;
      exp_t        e;
      if (rst) begin
         m_led = '0; m_rdata = '0; m_stable = '0; m_flag = 1'b0;
         m_pipe[0] = '0; m_pipe[1] = '0;
         m_win.delete();
      end else begin
         smp = m_pipe[1];
         m_pipe[1] = m_pipe[0];
         m_pipe[0] = sw;
         m_win.push_back(smp);
         if (m_win.size() > D) void'(m_win.pop_front());
         upd = (m_win.size() == D) && (m_win[0] != m_stable);
         for (int i = 1; i < m_win.size(); i++)
            if (m_win[i] != m_win[0]) upd = 0;
         if (io_sel) begin
            if (!io_we) begin
               case (io_addr)
                  ADDR_LED:   m_rdata = m_led;
                  ADDR_SW:    m_rdata = m_stable;
                  ADDR_SWCHG: m_rdata = {23'b0, m_flag};
                  default:    m_rdata = '0;
               endcase
               if (io_addr == ADDR_SWCHG) m_flag = 1'b0;
            end else if (io_addr == ADDR_LED) begin
               m_led = io_wdata;
            end
            e.rdata = m_rdata;
            e.led   = m_led;
            exp_q.push_back(e);
         end
         if (upd) begin
            m_flag   = 1'b1;
            m_stable = smp;
         end
      end
   end

   always @(negedge clk) begin : monitor
      exp_t e;
      if (exp_q.size() > 0 || io_ready === 1'b1) begin
         check("ready", {23'b0, io_ready}, {23'b0, exp_q.size() > 0});
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (io_ready === 1'b1) begin
               check("rdata", io_rdata, e.rdata);
               check("led", led, e.led);
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input bit we, input logic [7:0] a, input logic [23:0] d);
      io_sel = 1'b1; io_we = we; io_addr = a; io_wdata = d;
      cyc();
      io_sel = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) cyc();
   endtask

   logic [7:0] addrs[5];

   initial begin
      addrs = '{8'h60, 8'h70, 8'h74, 8'h44, 8'h00};
      rst = 1'b1; sw = 24'hFFFFFF;
      io_sel = 1'b1; io_we = 1'b1; io_addr = ADDR_LED; io_wdata = 24'hFFFFFF;
      repeat (5) cyc();
      check("rst_led", led, 24'h0);
      check("rst_ready", {23'b0, io_ready}, 24'h0);
      check("rst_rdata", io_rdata, 24'h0);
      io_sel = 1'b0; rst = 1'b0;
      req(0, ADDR_SWCHG, 0);
      check("flag_after_rst", io_rdata, 24'h0);
      sw = 24'h0;
      idle(25);
      req(0, ADDR_SWCHG, 0);

      req(1, ADDR_LED, 24'hA5A5A5);
      check("led_wr", led, 24'hA5A5A5);
      req(0, ADDR_LED, 0);
      check("led_rd", io_rdata, 24'hA5A5A5);

      sw = 24'h00F00F;
      repeat (22) req(0, ADDR_SW, 0);
      check("deb_val", io_rdata, 24'h00F00F);
      req(0, ADDR_SWCHG, 0);
      check("flag_set", io_rdata, 24'h1);
      req(0, ADDR_SWCHG, 0);
      check("flag_clr", io_rdata, 24'h0);

      sw = 24'h0;
      idle(25);
      req(0, ADDR_SWCHG, 0);
      for (int t = 0; t < 12; t++) begin
         sw = sw ^ 24'h000008;
         repeat (5) req(0, ADDR_SWCHG, 0);
      end
      sw = 24'h000008;
      repeat (22) req(0, ADDR_SW, 0);
      check("bounce_val", io_rdata, 24'h000008);
      req(0, ADDR_SWCHG, 0);

      req(1, ADDR_SW, 24'h123456);
      req(0, 8'h44, 0);
      check("unmapped_rd", io_rdata, 24'h0);
      req(0, ADDR_SW, 0);
      check("ro_unchanged", io_rdata, 24'h000008);

      sw = 24'h0;
      repeat (22) req(0, ADDR_SWCHG, 0);

      sw = 24'hFFFFFF;
      idle(8);
      rst = 1'b1; io_sel = 1'b1; io_we = 1'b0; io_addr = ADDR_LED;
      cyc();
      io_sel = 1'b0;
      cyc();
      rst = 1'b0;
      repeat (24) req(0, ADDR_SW, 0);

      for (int n = 0; n < 500; n++) begin
         case ($urandom_range(0, 19))
            0:       sw = 24'($urandom());
            1:       sw = sw ^ (24'h1 << $urandom_range(0, 23));
            default: ;
         endcase
         rst      = ($urandom_range(0, 149) == 0);
         io_sel   = ($urandom_range(0, 3) != 0);
         io_we    = ($urandom_range(0, 2) == 0);
         io_addr  = ($urandom_range(0, 9) == 0) ? 8'($urandom()) : addrs[$urandom_range(0, 4)];
         io_wdata = 24'($urandom());
         cyc();
      end
      rst = 1'b0; io_sel = 1'b0;
      idle(3);
      check("drain", 24'(exp_q.size()), 24'h0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
